// File: rtl/inst_fetch.sv
// Instruction-fetch front end: takes the fetch PC, issues one word read on the
// SRAM-like instruction bus, and hands {pc, inst, adel} to decode through a
// one-entry buffer. Responses still in flight when a flush arrives are dropped.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pc_i, pc_stall            fetch PC in; hold request back to the PC register
//   flush_i                   branch taken / exception / eret pulse
//   inst_req..inst_data_ok    SRAM-like instruction bus (read only)
//   id_valid, id_pc, id_inst, id_adel, id_ready   buffer towards decode
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_stall,
  input  logic        flush_i,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel,
  input  logic        id_ready
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              cancel, cancel_n;
  logic              req_n;
  logic [XLEN-1:0]   addr_n;
  logic              valid_n;
  logic              load;
  logic [XLEN-1:0]   load_pc;
  logic [XLEN-1:0]   load_inst;
  logic              load_adel;
  logic              buf_free;

  // Read-only bus: constant write controls.
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_wdata = '0;

  assign buf_free = !id_valid || id_ready;

  // State register plus registered bus outputs and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cancel    <= 1'b0;
      id_valid  <= 1'b0;
      id_pc     <= RESET_PC;
      id_inst   <= '0;
      id_adel   <= 1'b0;
      inst_req  <= 1'b0;
      inst_addr <= '0;
    end else begin
      state     <= state_n;
      cancel    <= cancel_n;
      id_valid  <= valid_n;
      inst_req  <= req_n;
      inst_addr <= addr_n;
      if (load) begin
        id_pc   <= load_pc;
        id_inst <= load_inst;
        id_adel <= load_adel;
      end
    end
  end

  // Next state, bus request, buffer load and PC stall.
  // inst_addr doubles as the latched fetch address for the whole transaction.
  always_comb begin
    state_n   = state;
    cancel_n  = cancel;
    req_n     = inst_req;
    addr_n    = inst_addr;
    pc_stall  = 1'b1;
    load      = 1'b0;
    load_pc   = inst_addr;
    load_inst = inst_rdata;
    load_adel = 1'b0;

    case (state)
      S_IDLE: begin
        if (!flush_i && buf_free) begin
          pc_stall = 1'b0;
          if (pc_i[1:0] == 2'b00) begin
            state_n = S_REQ;
            req_n   = 1'b1;
            addr_n  = pc_i;
          end else begin
            // Misaligned PC: report the address error without touching the bus.
            load      = 1'b1;
            load_pc   = pc_i;
            load_inst = '0;
            load_adel = 1'b1;
          end
        end
      end
      S_REQ: begin
        // A flush cannot withdraw a request; remember to drop its response.
        if (flush_i) cancel_n = 1'b1;
        if (inst_addr_ok) begin
          state_n = S_WAIT;
          req_n   = 1'b0;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_n  = S_IDLE;
          cancel_n = 1'b0;
          if (!cancel && !flush_i) load = 1'b1;
        end else if (flush_i) begin
          cancel_n = 1'b1;
        end
      end
      default: begin
        state_n  = S_IDLE;
        cancel_n = 1'b0;
        req_n    = 1'b0;
      end
    endcase

    valid_n = id_valid;
    if (flush_i || (id_valid && id_ready)) valid_n = 1'b0;
    if (load) valid_n = 1'b1;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed walk through the main scenarios followed by
// randomized PC / flush / ready / bus-timing traffic, all checked against a
// queue of consumed PCs and an address-derived memory image.
module tb_inst_fetch;

  localparam logic [31:0] RPC = 32'hbfbf_fff0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_stall;
  logic        flush_i;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;
  logic        id_ready;

  inst_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_stall(pc_stall), .flush_i(flush_i),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stimulus knobs.
  logic        rst_v = 1'b1, flush_v = 1'b0, ready_v = 1'b1, rand_bus = 1'b0;
  logic [31:0] pc_cur = 32'h0;
  int          aw = 0, dw = 0;

  // Bus slave state and scoreboard.
  logic [31:0] q[$];
  logic        pend = 1'b0, hold = 1'b0, prev_flush = 1'b0, took = 1'b0;
  logic [31:0] paddr = 32'h0, hold_addr = 32'h0;
  int          dcnt = 0, rcnt = 0, delivered = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hbfc0_0000) return 32'h3c1d_8000;
    if (a == 32'hbfc0_0004) return 32'hdead_beef;
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One clock: drive inputs on the falling edge, observe 2 time units later
  // and account for what the next rising edge will do.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    rst          = rst_v;
    flush_i      = flush_v;
    id_ready     = ready_v;
    pc_i         = pc_cur;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (!rst_v && pend && dcnt == 0) begin
      inst_data_ok = 1'b1;
      inst_rdata   = mem_word(paddr);
    end
    if (!rst_v && inst_req && !pend)
      inst_addr_ok = rand_bus ? ($urandom_range(0, 2) != 0) : (rcnt >= aw);
    #2;
    if (rst_v) begin
      q.delete();
      pend = 1'b0; hold = 1'b0; rcnt = 0; took = 1'b0; prev_flush = 1'b0;
    end else begin
      if (prev_flush) chk("flush_clr", 32'(id_valid), 32'd0);
      if (inst_req) begin
        chk("one_out", 32'(pend), 32'd0);
        chk("addr_align", 32'(inst_addr[1:0]), 32'd0);
      end
      if (hold) begin
        chk("req_hold", 32'(inst_req), 32'd1);
        chk("addr_hold", inst_addr, hold_addr);
      end
      if (inst_data_ok) pend = 1'b0;
      else if (pend && dcnt > 0) dcnt--;
      if (inst_req && inst_addr_ok) begin
        pend = 1'b1; paddr = inst_addr; rcnt = 0; hold = 1'b0;
        dcnt = rand_bus ? int'($urandom_range(0, 3)) : dw;
      end else if (inst_req) begin
        rcnt++; hold = 1'b1; hold_addr = inst_addr;
      end else begin
        hold = 1'b0;
      end
      if (flush_v) begin
        chk("flush_stall", 32'(pc_stall), 32'd1);
        q.delete();
        took = 1'b0;
      end else begin
        if (id_valid && id_ready) begin
          if (q.size() == 0) begin
            chk("spurious", 32'(id_valid), 32'd0);
          end else begin
            e = q.pop_front();
            delivered++;
            chk("sb_pc", id_pc, e);
            chk("sb_adel", 32'(id_adel), 32'(e[1:0] != 2'b00));
            chk("sb_inst", id_inst, (e[1:0] != 2'b00) ? 32'h0 : mem_word(e));
          end
        end
        took = !pc_stall;
        if (took) q.push_back(pc_cur);
      end
      prev_flush = flush_v;
      chk("q_depth", 32'(q.size() <= 2), 32'd1);
    end
  endtask

  task automatic chk_reset();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, RPC);
    chk("rst_inst", id_inst, 32'd0);
    chk("rst_adel", 32'(id_adel), 32'd0);
    chk("rst_req", 32'(inst_req), 32'd0);
    chk("rst_addr", inst_addr, 32'd0);
    chk("tie_wr", 32'(inst_wr), 32'd0);
    chk("tie_size", 32'(inst_size), 32'd2);
    chk("tie_wdata", inst_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; id_ready = 1'b1; pc_i = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

    // Reset and first zero-wait fetch.
    step(); step();
    rst_v = 1'b0; pc_cur = 32'hbfc0_0000; aw = 0; dw = 0;
    step();                                   // cycle 0
    chk_reset();
    chk("c0_stall", 32'(pc_stall), 32'd0);
    pc_cur = 32'hbfc0_0004;
    step();                                   // cycle 1
    chk("c1_req", 32'(inst_req), 32'd1);
    chk("c1_addr", inst_addr, 32'hbfc0_0000);
    ready_v = 1'b0;
    step();                                   // cycle 2
    chk("c2_req", 32'(inst_req), 32'd0);
    chk("c2_stall", 32'(pc_stall), 32'd1);

    // Decode back-pressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step();                                 // cycles 3..7
      chk("bp_valid", 32'(id_valid), 32'd1);
      chk("bp_pc", id_pc, 32'hbfc0_0000);
      chk("bp_inst", id_inst, 32'h3c1d_8000);
      chk("bp_stall", 32'(pc_stall), 32'd1);
      chk("bp_req", 32'(inst_req), 32'd0);
    end
    ready_v = 1'b1; dw = 2;
    step();                                   // cycle 8
    chk("bp_release", 32'(pc_stall), 32'd0);
    pc_cur = 32'hbfc0_0008;
    step();                                   // cycle 9
    chk("f1_req", 32'(inst_req), 32'd1);
    chk("f1_addr", inst_addr, 32'hbfc0_0004);

    // Flush while waiting; late data must be dropped.
    flush_v = 1'b1;
    step();                                   // cycle 10
    flush_v = 1'b0; pc_cur = 32'hbfc0_0380; dw = 0;
    for (int i = 0; i < 2; i++) begin
      step();                                 // cycles 11, 12
      chk("f1_novalid", 32'(id_valid), 32'd0);
      chk("f1_stall", 32'(pc_stall), 32'd1);
    end
    step();                                   // cycle 13
    chk("f1_idle", 32'(pc_stall), 32'd0);
    chk("f1_drop", 32'(id_valid), 32'd0);
    pc_cur = 32'hbfc0_0384;
    step();                                   // cycle 14
    chk("f1_addr2", inst_addr, 32'hbfc0_0380);
    step();                                   // cycle 15
    step();                                   // cycle 16
    chk("f1_valid", 32'(id_valid), 32'd1);
    chk("f1_pc", id_pc, 32'hbfc0_0380);
    chk("f1_inst", id_inst, mem_word(32'hbfc0_0380));

    // Flush coincident with data_ok.
    pc_cur = 32'hbfc0_0388; dw = 1;
    step();                                   // cycle 17
    step();                                   // cycle 18
    flush_v = 1'b1;
    step();                                   // cycle 19
    flush_v = 1'b0; pc_cur = 32'hbfc0_0400; dw = 0;
    step();                                   // cycle 20
    chk("f2_novalid", 32'(id_valid), 32'd0);
    chk("f2_idle", 32'(pc_stall), 32'd0);
    pc_cur = 32'hbfc0_0404;
    step();                                   // cycle 21
    chk("f2_addr", inst_addr, 32'hbfc0_0400);
    step();                                   // cycle 22
    chk("f2_novalid2", 32'(id_valid), 32'd0);

    // Misaligned PC consumed as the post-flush fetch is delivered.
    pc_cur = 32'hbfc0_0002;
    step();                                   // cycle 23
    chk("f2_valid", 32'(id_valid), 32'd1);
    chk("f2_pc", id_pc, 32'hbfc0_0400);
    chk("adel_stall", 32'(pc_stall), 32'd0);
    pc_cur = 32'hbfc0_0010; dw = 10;
    step();                                   // cycle 24
    chk("adel_req", 32'(inst_req), 32'd0);
    chk("adel_valid", 32'(id_valid), 32'd1);
    chk("adel_flag", 32'(id_adel), 32'd1);
    chk("adel_inst", id_inst, 32'd0);
    chk("adel_pc", id_pc, 32'hbfc0_0002);

    // Reset while waiting on a response that never arrives.
    step();                                   // cycle 25
    step();                                   // cycle 26
    step();                                   // cycle 27
    chk("w_stall", 32'(pc_stall), 32'd1);
    rst_v = 1'b1;
    step();                                   // cycle 28
    rst_v = 1'b0; pc_cur = 32'hbfc0_0020;
    step();                                   // cycle 29
    chk_reset();
    chk("r_stall", 32'(pc_stall), 32'd0);
    pc_cur = 32'hbfc0_0024;
    step();                                   // cycle 30
    chk("r_req", 32'(inst_req), 32'd1);
    chk("r_addr", inst_addr, 32'hbfc0_0020);

    // Randomized traffic.
    rand_bus = 1'b1; delivered = 0;
    for (int n = 0; n < 4000; n++) begin
      flush_v = ($urandom_range(0, 19) == 0);
      ready_v = ($urandom_range(0, 3) != 0);
      rst_v   = ($urandom_range(0, 599) == 0);
      step();
      if (flush_v || rst_v) begin
        pc_cur = 32'hbfc0_0000 + {20'h0, 10'($urandom), 2'b00};
      end else if (took) begin
        case ($urandom_range(0, 15))
          0:       pc_cur = (pc_cur & ~32'h3) + 32'd4 + 32'($urandom_range(1, 3));
          1:       pc_cur = 32'h8000_0000 + {18'h0, 12'($urandom), 2'b00};
          default: pc_cur = (pc_cur & ~32'h3) + 32'd4;
        endcase
      end
    end
    rst_v = 1'b0; flush_v = 1'b0;
    chk("progress", 32'(delivered > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end of the Loongson MIPS core. It sits between the PC register and decode. It samples the current fetch PC and issues one word read on the SRAM-like instruction bus. It returns the instruction with its PC to decode through a one-entry output buffer, stalls the PC while busy, and discards in-flight responses on flush (branch taken, exception, eret).

## Interface
Parameters:
- `RESET_PC`, 32'h0: value of `id_pc` after reset.

Ports:
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc_i` in 32: current fetch PC from the PC register.
- `pc_stall` out 1: 1 means the PC must hold; 0 means `pc_i` is consumed this cycle.
- `flush_i` in 1: 1-cycle pulse on branch taken, exception or eret.
- `inst_req` out 1: bus request.
- `inst_wr` out 1: tied to 0.
- `inst_size` out 2: tied to 2'b10.
- `inst_addr` out 32: request address, word aligned.
- `inst_wdata` out 32: tied to 0.
- `inst_addr_ok` in 1: request accepted.
- `inst_rdata` in 32: read data.
- `inst_data_ok` in 1: read data valid.
- `id_valid` out 1: output buffer holds an instruction.
- `id_pc` out 32: PC of the buffered instruction.
- `id_inst` out 32: instruction word; 0 when `id_adel`=1.
- `id_adel` out 1: fetch address error (misaligned PC).
- `id_ready` in 1: decode consumes the buffer this cycle when `id_valid`=1.

## Operation
- FSM states: IDLE, REQ, WAIT. At most one bus transaction outstanding.
- `buf_free` = !id_valid || id_ready.
- **IDLE**
  - If !flush_i && buf_free && pc_i[1:0]==0: latch `addr_r`<=pc_i, go to REQ, `pc_stall`=0.
  - If !flush_i && buf_free && pc_i[1:0]!=0: load the buffer with pc=pc_i, inst=0, adel=1. No bus request is issued. Stay in IDLE, `pc_stall`=0.
  - Otherwise `pc_stall`=1.
- **REQ**
  - `inst_req`=1 and `inst_addr`=`addr_r`, both held stable until `inst_addr_ok`.
  - On addr_ok, go to WAIT.
  - A flush in REQ does not drop the request. It sets `cancel`, and the request still completes.
- **WAIT**
  - On data_ok with !cancel && !flush_i: load the buffer {addr_r, inst_rdata, adel=0}, go to IDLE.
  - On data_ok with cancel || flush_i: discard the data, clear `cancel`, go to IDLE.
  - On flush_i without data_ok: set `cancel`.
- `pc_stall`=1 in REQ and WAIT.
- **Flush**: `id_valid`<=0 next cycle, regardless of `id_ready`. No PC is accepted in the flush cycle; the PC register updates itself from the branch or exception inputs.
- **Buffer**: when `id_ready` && `id_valid` and no new load, `id_valid`<=0. A load and a consume in the same cycle leave the buffer holding the new entry. A load only happens after `buf_free`, so no overflow is possible.
- **Reset**: state=IDLE, cancel=0, id_valid=0, id_pc=RESET_PC, id_inst=0, id_adel=0, inst_req=0, inst_addr=0. The bus is reset together with this block.

## Timing
- Best-case latency: pc_i sampled in cycle 0; req in cycle 1 with addr_ok in cycle 1; data_ok in cycle 2; id_valid in cycle 3.
- Throughput is at most one instruction per 3 cycles.
- `inst_req`/`inst_addr` are registered outputs, with no combinational path from `inst_addr_ok`.
- `pc_stall` is combinational from state, `id_valid`, `id_ready`, `flush_i`.
- Flush and data_ok in the same cycle: the data is discarded.
- Flush and addr_ok in the same cycle: go to WAIT with cancel=1.
- A response received after a flush is never delivered.

## Test plan
- Reset, then pc_i=0xbfc00000, memory returns 0x3c1d8000 with addr_ok and data_ok both zero-wait -> inst_req high in cycle 1 with addr 0xbfc00000; cycle 3 id_valid=1, id_pc=0xbfc00000, id_inst=0x3c1d8000.
- id_ready=0 for 5 cycles after the first delivery -> pc_stall=1 and no inst_req throughout; id_valid/id_inst stable; the next fetch starts the cycle id_ready=1.
- flush_i pulse while in WAIT, data_ok 2 cycles later with 0xdeadbeef -> id_valid stays 0, FSM returns to IDLE, next pc_i (0xbfc00380) fetched and delivered normally.
- flush_i in the same cycle as data_ok -> data dropped, cancel=0 afterwards, no spurious id_valid.
- pc_i=0xbfc00002 -> no inst_req; next cycle id_valid=1, id_adel=1, id_inst=0, id_pc=0xbfc00002.
- rst asserted during WAIT, then data_ok is not raised by the bus -> all outputs at reset values, FSM in IDLE, fetch resumes from pc_i after rst drops.
